frame_rr_arbiter: RTL and testbench

//  Round-robin frame scheduler between the ADC_CHANEL per-channel packaged-data FIFOs (fifo_32x128, clk_100m read side)
//  and the final data FIFO. Replaces the word-interleaved drain with whole-frame grants: one channel owns the output
//  for FRAME_WORDS words (header..tail), then the grant rotates. Sits between adc_data_fifo instances and data_fifo_wr_*.

---
 rtl/frame_rr_arbiter_pkg.sv | 17 +
 rtl/frame_rr_arbiter_rr_pick.sv | 28 ++
 rtl/frame_rr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_frame_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rr_arbiter_pkg.sv
// Shared constants for frame_rr_arbiter: FSM state encoding, data slice width and filler format.
package frame_rr_arbiter_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StXfer  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [15:0] FillerTag = 16'hDEAD;

  // Word written in place of each missing word of an aborted frame.
  function automatic logic [DataW-1:0] filler_word(input logic [3:0] ch);
    return {FillerTag, ch, 12'h000};
  endfunction

endpackage

// File: rtl/frame_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first requester strictly after last_i, wrapping modulo N.
module frame_rr_arbiter_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] grant_o,
  output logic         valid_o
);

  always_comb begin
    int unsigned idx;
    grant_o = last_i;
    valid_o = 1'b0;
    idx     = 0;
    // off == N wraps back to last_i itself, so a lone requester can be regranted.
    for (int unsigned off = 1; off <= N; off++) begin
      idx = 32'(last_i) + off;
      if (idx >= N) idx = idx - N;
      if (!valid_o && req_i[idx[W-1:0]]) begin
        valid_o = 1'b1;
        grant_o = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Round-robin whole-frame scheduler from per-channel FIFOs into one output FIFO.
// Optional mid-frame starvation abort with filler flush: define FRAME_ARB_TIMEOUT_EN.
module frame_rr_arbiter
  import frame_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADC_CHANEL     = 4,
  parameter int unsigned FRAME_WORDS    = 260,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ChW = (ADC_CHANEL > 1) ? $clog2(ADC_CHANEL) : 1
) (
  input  logic                        clk_100m,
  input  logic                        reset_n,
  input  logic                        arb_enable,
  input  logic [ADC_CHANEL-1:0]       ch_empty,
  input  logic [DataW*ADC_CHANEL-1:0] ch_dout,
  output logic [ADC_CHANEL-1:0]       ch_rden,
  input  logic                        out_almost_full,
  output logic                        out_wr_en,
  output logic [DataW-1:0]            out_din,
  output logic [ChW-1:0]              grant_ch,
  output logic                        busy,
  output logic [31:0]                 frame_cnt,
  output logic [15:0]                 timeout_cnt
);

  localparam int unsigned WordW = $clog2(FRAME_WORDS);
  localparam logic [WordW-1:0] LastWord = WordW'(FRAME_WORDS - 1);

  if (ADC_CHANEL < 1 || ADC_CHANEL > 16 || FRAME_WORDS < 2 || TIMEOUT_CYCLES < 2)
  begin : g_param_check
    $error("frame_rr_arbiter: parameter out of range");
  end

  logic [1:0]       state_q, state_d;
  logic [ChW-1:0]   grant_q, grant_d;
  logic [WordW-1:0] word_q, word_d;
  logic [31:0]      frame_q, frame_d;
  logic             wr_q, fill_q;
  logic [ChW-1:0]   src_q;
  logic             rd, fill_wr, last_word;
  logic             pick_valid;
  logic [ChW-1:0]   pick_ch;
  logic [DataW-1:0] dout_arr [ADC_CHANEL];

`ifdef FRAME_ARB_TIMEOUT_EN
  localparam int unsigned StarveW = $clog2(TIMEOUT_CYCLES);
  localparam logic [StarveW-1:0] StarveLast = StarveW'(TIMEOUT_CYCLES - 1);
  logic [StarveW-1:0] starve_q, starve_d;
  logic [15:0]        tmo_q, tmo_d;
`endif

  for (genvar k = 0; k < ADC_CHANEL; k++) begin : g_slice
    assign dout_arr[k] = ch_dout[DataW*k +: DataW];
  end

  frame_rr_arbiter_rr_pick #(
    .N (ADC_CHANEL),
    .W (ChW)
  ) u_pick (
    .req_i   (~ch_empty),
    .last_i  (grant_q),
    .grant_o (pick_ch),
    .valid_o (pick_valid)
  );

  assign last_word = (word_q == LastWord);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    word_d  = word_q;
    frame_d = frame_q;
    ch_rden = '0;
    rd      = 1'b0;
    fill_wr = 1'b0;
`ifdef FRAME_ARB_TIMEOUT_EN
    starve_d = starve_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      StIdle: begin
        if (arb_enable && pick_valid) begin
          grant_d = pick_ch;
          word_d  = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Output back-pressure wins over data availability.
        rd               = ~ch_empty[grant_q] & ~out_almost_full;
        ch_rden[grant_q] = rd;
        if (rd) begin
          if (last_word) begin
            frame_d = frame_q + 32'd1;
            word_d  = '0;
            state_d = StIdle;
          end else begin
            word_d = word_q + WordW'(1);
          end
`ifdef FRAME_ARB_TIMEOUT_EN
          starve_d = '0;
        end else if (!out_almost_full) begin
          if (starve_q == StarveLast) begin
            starve_d = '0;
            state_d  = StFlush;
          end else begin
            starve_d = starve_q + StarveW'(1);
          end
`endif
        end
      end
`ifdef FRAME_ARB_TIMEOUT_EN
      StFlush: begin
        // word_q keeps counting so the frame is padded to its full length.
        if (!out_almost_full) begin
          fill_wr = 1'b1;
          if (last_word) begin
            word_d  = '0;
            state_d = StIdle;
            if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          end else begin
            word_d = word_q + WordW'(1);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= ChW'(ADC_CHANEL - 1);
      word_q  <= '0;
      frame_q <= '0;
      wr_q    <= 1'b0;
      fill_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      word_q  <= word_d;
      frame_q <= frame_d;
      wr_q    <= rd | fill_wr;
      fill_q  <= fill_wr;
      src_q   <= grant_q;
    end
  end

`ifdef FRAME_ARB_TIMEOUT_EN
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  assign timeout_cnt = tmo_q;
`else
  assign timeout_cnt = 16'h0000;
`endif

  // Non-FWFT FIFO data arrives the cycle after rden, aligned with the registered write strobe.
  always_comb begin
    out_din = '0;
    if (wr_q) out_din = fill_q ? filler_word(4'(src_q)) : dout_arr[src_q];
  end

  assign out_wr_en = wr_q;
  assign grant_ch  = grant_q;
  assign busy      = (state_q == StXfer) || (state_q == StFlush);
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Scoreboard bench for frame_rr_arbiter: FIFO models feed the DUT, a monitor checks every write.
module tb_frame_rr_arbiter;

  localparam int unsigned NCh = 4;
  localparam int unsigned FW  = 260;
`ifdef FRAME_ARB_TIMEOUT_EN
  localparam int unsigned Tmo         = 16;
  localparam int          StallCycles = 10;
  localparam int          TmoFinal    = 1;
`else
  localparam int unsigned Tmo         = 4096;
  localparam int          StallCycles = 50;
  localparam int          TmoFinal    = 0;
`endif

  logic              clk_100m        = 1'b0;
  logic              reset_n         = 1'b1;
  logic              arb_enable      = 1'b0;
  logic              out_almost_full = 1'b0;
  logic [NCh-1:0]    ch_empty        = '1;
  logic [32*NCh-1:0] ch_dout         = '0;
  logic [NCh-1:0]    ch_rden;
  logic              out_wr_en;
  logic [31:0]       out_din;
  logic [1:0]        grant_ch;
  logic              busy;
  logic [31:0]       frame_cnt;
  logic [15:0]       timeout_cnt;

  frame_rr_arbiter #(
    .ADC_CHANEL     (NCh),
    .FRAME_WORDS    (FW),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk_100m        (clk_100m),
    .reset_n         (reset_n),
    .arb_enable      (arb_enable),
    .ch_empty        (ch_empty),
    .ch_dout         (ch_dout),
    .ch_rden         (ch_rden),
    .out_almost_full (out_almost_full),
    .out_wr_en       (out_wr_en),
    .out_din         (out_din),
    .grant_ch        (grant_ch),
    .busy            (busy),
    .frame_cnt       (frame_cnt),
    .timeout_cnt     (timeout_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  int          base = 0;
  logic [31:0] fq [NCh][$];
  logic [31:0] exp_q [$];
  logic [31:0] pop_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [31:0] word(input int ch, input int fr, input int i);
    return {4'hA, 4'(ch), 8'(fr), 16'(i)};
  endfunction

  task automatic load(input int ch, input int fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fq[ch].push_back(word(ch, fr, i));
  endtask

  task automatic expect_w(input int ch, input int fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(word(ch, fr, i));
  endtask

  task automatic frame(input int ch, input int fr);
    load(ch, fr, 0, FW - 1);
    expect_w(ch, fr, 0, FW - 1);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int i = 0;
    while (frame_cnt != 32'(n) && i < budget) begin
      @(negedge clk_100m);
      i++;
    end
    chk(name, frame_cnt, 32'(n));
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int i = 0;
    while (wr_cnt < n && i < budget) begin
      @(negedge clk_100m);
      i++;
    end
    chk(name, 32'(wr_cnt >= n), 32'd1);
  endtask

  task automatic flush_models();
    for (int k = 0; k < NCh; k++) fq[k].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk_100m);
    #2 reset_n = 1'b0;
    flush_models();
    repeat (2) @(posedge clk_100m);
    #2 reset_n = 1'b1;
  endtask

  // Standard (non-FWFT) channel FIFOs: data one cycle after rden, empty updates on the clock.
  always @(posedge clk_100m) begin
    cyc++;
    for (int k = 0; k < NCh; k++) begin
      if (ch_rden[k]) begin
        if (fq[k].size() == 0) begin
          n_total++;
          $display("FAIL fifo_underflow ch%0d: got rden=1 required rden=0", k);
        end else begin
          pop_w = fq[k].pop_front();
          ch_dout[32*k +: 32] <= pop_w;
        end
      end
      ch_empty[k] <= (fq[k].size() == 0);
    end
  end

  always @(negedge clk_100m) begin
    if (out_wr_en) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got %h required no write", out_din);
      end else begin
        chk("out_din", out_din, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    arb_enable = 1'b1;
    repeat (3) @(negedge clk_100m);
    chk("rst_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_rden", 32'(ch_rden), 32'd0);
    chk("rst_din", out_din, 32'd0);
    chk("rst_grant", 32'(grant_ch), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    @(posedge clk_100m);
    #2 reset_n = 1'b1;

    // Single ch0 frame, streamed back to back.
    @(negedge clk_100m);
    first_wr = -1;
    base = wr_cnt;
    frame(0, 0);
    wait_frames(1, 400, "t1_frame_cnt");
    repeat (3) @(negedge clk_100m);
    chk("t1_contiguous", 32'(last_wr - first_wr), 32'(FW - 1));
    chk("t1_writes", 32'(wr_cnt - base), 32'(FW));
    chk("t1_grant", 32'(grant_ch), 32'd0);

    // Output back-pressure mid-frame on ch1.
    base = wr_cnt;
    frame(1, 0);
    wait_writes(base + 50, 200, "t3_reach_50");
    @(negedge clk_100m);
    out_almost_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("t3_rden_afull", 32'(ch_rden), 32'd0);
      @(negedge clk_100m);
    end
    out_almost_full = 1'b0;
    wait_frames(2, 400, "t3_frame_cnt");

    // ch2 runs dry after 100 words while ch3 waits with a full frame.
    base = wr_cnt;
    load(2, 0, 0, 99);
    expect_w(2, 0, 0, FW - 1);
    frame(3, 0);
    wait_writes(base + 100, 300, "t4_reach_100");
    for (int i = 0; i < StallCycles; i++) begin
      @(negedge clk_100m);
      #1 chk("t4_stall_rden", 32'(ch_rden), 32'd0);
      chk("t4_stall_grant", 32'(grant_ch), 32'd2);
      chk("t4_stall_busy", 32'(busy), 32'd1);
    end
    load(2, 0, 100, FW - 1);
    wait_frames(4, 800, "t4_frame_cnt");
    repeat (3) @(negedge clk_100m);
    chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // All channels, two frames each, from reset.
    do_reset();
    @(negedge clk_100m);
    chk("t2_rst_grant", 32'(grant_ch), 32'd3);
    chk("t2_rst_frame_cnt", frame_cnt, 32'd0);
    for (int fr = 0; fr < 2; fr++)
      for (int ch = 0; ch < NCh; ch++) frame(ch, fr);
    wait_frames(8, 2600, "t2_frame_cnt");
    repeat (3) @(negedge clk_100m);
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_grant", 32'(grant_ch), 32'd3);

    // arb_enable: no grant while low; a mid-frame drop still finishes that frame only.
    arb_enable = 1'b0;
    base = wr_cnt;
    load(0, 1, 0, FW - 1);
    load(0, 2, 0, FW - 1);
    expect_w(0, 1, 0, FW - 1);
    repeat (20) @(negedge clk_100m);
    chk("en_idle_busy", 32'(busy), 32'd0);
    chk("en_idle_writes", 32'(wr_cnt - base), 32'd0);
    arb_enable = 1'b1;
    wait_writes(base + 30, 100, "en_reach_30");
    arb_enable = 1'b0;
    wait_frames(9, 400, "en_frame_cnt");
    repeat (20) @(negedge clk_100m);
    chk("en_hold_busy", 32'(busy), 32'd0);
    chk("en_hold_frame_cnt", frame_cnt, 32'd9);
    chk("en_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame, then ch0 must win over ch1.
    base = wr_cnt;
    expect_w(0, 2, 0, FW - 1);
    arb_enable = 1'b1;
    wait_writes(base + 50, 100, "t6_reach_50");
    @(posedge clk_100m);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rden", 32'(ch_rden), 32'd0);
    chk("t6_wr_en", 32'(out_wr_en), 32'd0);
    chk("t6_din", out_din, 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_grant", 32'(grant_ch), 32'd3);
    chk("t6_frame_cnt", frame_cnt, 32'd0);
    flush_models();
    repeat (2) @(posedge clk_100m);
    #2 reset_n = 1'b1;
    @(negedge clk_100m);
    frame(0, 3);
    frame(1, 3);
    wait_frames(2, 700, "t6_frame_cnt");
    repeat (3) @(negedge clk_100m);
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef FRAME_ARB_TIMEOUT_EN
    // ch1 starves after 10 words; the rest of the frame is padded with filler.
    do_reset();
    @(negedge clk_100m);
    load(1, 4, 0, 9);
    expect_w(1, 4, 0, 9);
    for (int i = 0; i < 250; i++) exp_q.push_back(32'hDEAD1000);
    begin
      int i = 0;
      while (timeout_cnt != 16'd1 && i < 600) begin
        @(negedge clk_100m);
        i++;
      end
    end
    repeat (3) @(negedge clk_100m);
    chk("t5_timeout_cnt", 32'(timeout_cnt), 32'd1);
    chk("t5_frame_cnt", frame_cnt, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);
`endif

    chk("final_timeout_cnt", 32'(timeout_cnt), 32'(TmoFinal));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
